skew_lane_buffer: RTL and testbench
===================================

# skew_lane_buffer

Parametrised successor to the systolic-array B-operand skew buffer. Accepts one DIM-wide row per cycle and delays each lane by a lane-dependent number of cycles. Two modes: skew (diagonal feed into the array) and deskew (re-aligning diagonal array outputs into rows). Adds a valid tag per lane, global stall, zero-bubble insertion, matrix framing and a drain-complete pulse.

## Interface
- BITS, 8, element width (signed)
- DIM, 8, number of lanes; maximum lane delay is DIM
- ROWS, 8, rows per matrix frame; ROWS ≥ 1
- clk  in  1  clock, all state updates on posedge
- rst_n  in  1  synchronous active-low reset
- en  in  1  advance enable; 0 freezes all state (stall)
- deskew  in  1  mode request: 0 = skew, 1 = deskew
- vin  in  1  din holds a valid row this cycle
- din  in  DIM×BITS signed  input row, lane c = din[c]
- dout  out  DIM×BITS signed  lane outputs; 0 when the lane's valid is 0
- vout  out  DIM  per-lane valid
- busy  out  1  any valid entry held in any lane
- mode  out  1  active mode register
- done  out  1  one-cycle pulse when the last element of a frame exits
- row_cnt  out  $clog2(ROWS+1)  rows accepted in the current frame

## Operation
- Each lane c is a DIM-stage shift register of {data, valid, last}. Tap index is L_c: skew L_c = c+1; deskew L_c = DIM−c.
- Row accepted on posedge where en=1 and vin=1. Stage 0 of every lane loads din[c], valid=1, last=(row_cnt==ROWS−1).
- en=1, vin=0: stage 0 loads {0,0,0} (bubble).
- en=0: no stage, counter, mode or done change; done forced 0 during stall cycles. vin/din ignored.
- dout[c]/vout[c] driven from stage L_c−1 of lane c; dout[c]=0 whenever vout[c]=0.
- row_cnt increments per accepted row; wraps to 0 on the accept that makes it ROWS.
- Mode: mode register loads deskew on any posedge where busy=0 (independent of en). While busy=1 deskew is ignored. Mode therefore never changes with data in flight; deskew must be set ≥1 cycle before the first vin of a frame.
- done = 1 in the cycle the last-tagged entry is visible on the longest-delay lane (skew: lane DIM−1; deskew: lane 0). Exactly one pulse per frame.
- busy = OR of all valid bits in all stages up to each lane's tap.
- Reset (rst_n=0 on posedge): all data/valid/last stages 0, mode=0, row_cnt=0. Outputs after reset: dout all 0, vout 0, busy 0, done 0, mode 0, row_cnt 0. Reset mid-frame discards all in-flight data with no done pulse.

## Timing
- Row r accepted at edge k+r (continuous en=1): lane c presents it in the cycle after edge k+r+L_c−1.
- Skew, DIM=8: row 0 lane 0 visible after edge k, lane 7 after edge k+7. Frame of ROWS rows drains ROWS+DIM−1 cycles after first accept; done coincident with last output.
- Deskew: all lanes share total delay with a diagonal input, i.e. element of array column c entering at edge k+c exits at edge k+DIM−1 on every lane simultaneously.
- Stall cycles add one cycle to every in-flight latency; no data lost or duplicated.
- vin=1 on the same edge that completes a frame is legal; frames may be back-to-back with no gap in the same mode.
- Mode change requires busy=0; first post-change accept occurs ≥1 cycle after busy deasserts.

## Test plan
- Reset then skew, DIM=8, ROWS=8, row r = {r*8+c}: lane c shows r*8+c exactly r+c+1 edges after row 0 accept; zeros/vout=0 elsewhere; done once at 15th output cycle; busy low afterward.
- Deskew, lane c fed value 10+c at edge k+c with other lanes bubbles: all lanes show 10+c simultaneously after edge k+7, vout=8'hFF for one cycle.
- Stall: skew frame with en=0 for 3 cycles mid-drain: outputs frozen during stall, sequence resumes identical, done shifted by exactly 3 cycles.
- Back-to-back two frames (ROWS=4): row_cnt 0→3→0→3, two done pulses 4 cycles apart, no gap or corruption between frames.
- Mode change attempt with busy=1: deskew toggled mid-frame, mode stays 0 until busy=0, then loads 1 next edge.
- rst_n=0 mid-frame with 3 rows in flight: next cycle dout=0, vout=0, busy=0, row_cnt=0, mode=0, no done pulse.

Source files
------------

// File: rtl/skew_lane_buffer_if.sv
// -----------------------------------------------------------------------------
// skew_lane_buffer_if
// Bundles the row-in / lane-out signals of skew_lane_buffer.
//   en       advance enable (0 = stall, all state frozen)
//   deskew   mode request: 0 = skew, 1 = deskew
//   vin      din carries a valid row this cycle
//   din      input row, lane c = din[c] (signed BITS-bit elements)
//   dout     lane outputs, zero when the lane's vout bit is 0
//   vout     per-lane valid
//   busy     some valid entry is still held ahead of a lane tap
//   mode     active mode register
//   done     one-cycle pulse when the last element of a frame exits
//   row_cnt  rows accepted in the current frame
// master drives the row side; slave is the buffer itself.
// -----------------------------------------------------------------------------
interface skew_lane_buffer_if #(
   parameter int BITS = 8,
   parameter int DIM  = 8,
   parameter int ROWS = 8
);
   localparam int CW = $clog2(ROWS + 1);

   logic                      en;
   logic                      deskew;
   logic                      vin;
   logic [DIM-1:0][BITS-1:0]  din;
   logic [DIM-1:0][BITS-1:0]  dout;
   logic [DIM-1:0]            vout;
   logic                      busy;
   logic                      mode;
   logic                      done;
   logic [CW-1:0]             row_cnt;

   modport master (
      output en, deskew, vin, din,
      input  dout, vout, busy, mode, done, row_cnt
   );

   modport slave (
      input  en, deskew, vin, din,
      output dout, vout, busy, mode, done, row_cnt
   );
endinterface

// File: rtl/skew_lane_buffer.sv
// -----------------------------------------------------------------------------
// skew_lane_buffer
// Delays lane c of each accepted DIM-wide row by a lane-dependent number of
// cycles: skew mode taps lane c at delay c+1 (diagonal feed into an array),
// deskew mode taps it at delay DIM-c (re-aligns diagonal outputs into rows).
// Ports:
//   clk    clock, all state updates on posedge
//   rst_n  synchronous active-low reset
//   bus    skew_lane_buffer_if.slave (en, deskew, vin, din in;
//          dout, vout, busy, mode, done, row_cnt out)
// DIM must be at least 2; ROWS at least 1.
// -----------------------------------------------------------------------------
module skew_lane_buffer #(
   parameter int BITS = 8,
   parameter int DIM  = 8,
   parameter int ROWS = 8
) (
   input logic               clk,
   input logic               rst_n,
   skew_lane_buffer_if.slave bus
);
   localparam int CW = $clog2(ROWS + 1);
   localparam int IW = (DIM > 1) ? $clog2(DIM) : 1;

   // data_r[lane][stage]; every lane has DIM stages, only stages up to the
   // lane's tap are observable in the current mode.
   logic [BITS-1:0]           data_r [DIM][DIM];
   logic [DIM-1:0][DIM-1:0]   valid_r;
   // The last tag is identical across lanes (a whole row carries it), so a
   // single shared shift register holds it; per-lane valid qualifies it.
   logic [DIM-1:0]            last_r;
   logic                      mode_r;
   logic [CW-1:0]             row_cnt_r;

   logic                      accept_s;
   logic                      last_in_s;
   logic                      busy_s;
   logic                      done_s;
   logic [IW-1:0]             tap_s;
   logic [DIM-1:0]            vout_s;
   logic [DIM-1:0][BITS-1:0]  dout_s;

   assign accept_s  = bus.en & bus.vin;
   assign last_in_s = (row_cnt_r == CW'(ROWS - 1));

   // Lane shift registers, shared last tag, frame row counter and mode register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int c = 0; c < DIM; c++) begin
            for (int s = 0; s < DIM; s++) begin
               data_r[c][s] <= {BITS{1'b0}};
            end
         end
         valid_r   <= '0;
         last_r    <= '0;
         mode_r    <= 1'b0;
         row_cnt_r <= '0;
      end else begin
         // Mode may only follow the request while nothing is in flight,
         // so in-flight data never sees its tap move.
         if (!busy_s) begin
            mode_r <= bus.deskew;
         end
         if (bus.en) begin
            for (int c = 0; c < DIM; c++) begin
               data_r[c][0]  <= accept_s ? bus.din[c] : {BITS{1'b0}};
               valid_r[c][0] <= accept_s;
               for (int s = 1; s < DIM; s++) begin
                  data_r[c][s]  <= data_r[c][s-1];
                  valid_r[c][s] <= valid_r[c][s-1];
               end
            end
            last_r <= {last_r[DIM-2:0], accept_s & last_in_s};
            if (accept_s) begin
               row_cnt_r <= last_in_s ? CW'(0) : row_cnt_r + CW'(1);
            end
         end
      end
   end

   // Per-lane tap selection, zero-gated outputs and occupancy
   always_comb begin
      busy_s = 1'b0;
      vout_s = '0;
      dout_s = '0;
      tap_s  = '0;
      for (int c = 0; c < DIM; c++) begin
         tap_s     = mode_r ? IW'(DIM - 1 - c) : IW'(c);
         vout_s[c] = valid_r[c][tap_s];
         if (valid_r[c][tap_s]) begin
            dout_s[c] = data_r[c][tap_s];
         end else begin
            dout_s[c] = {BITS{1'b0}};
         end
         for (int s = 0; s < DIM; s++) begin
            if (s <= int'(tap_s)) begin
               busy_s = busy_s | valid_r[c][s];
            end else begin
               busy_s = busy_s;
            end
         end
      end
   end

   // Frame-done: the longest lane (skew: DIM-1, deskew: 0) taps stage DIM-1
   // in both modes. Gating with en makes the pulse land on the one cycle the
   // last entry is actually consumed, so a stall never repeats it.
   always_comb begin
      if (mode_r) begin
         done_s = bus.en & valid_r[0][DIM-1] & last_r[DIM-1];
      end else begin
         done_s = bus.en & valid_r[DIM-1][DIM-1] & last_r[DIM-1];
      end
   end

   assign bus.dout    = dout_s;
   assign bus.vout    = vout_s;
   assign bus.busy    = busy_s;
   assign bus.mode    = mode_r;
   assign bus.done    = done_s;
   assign bus.row_cnt = row_cnt_r;

endmodule

// File: tb/tb_skew_lane_buffer.sv
// -----------------------------------------------------------------------------
// tb_skew_lane_buffer
// Drives two buffers (ROWS=8 and ROWS=4) with identical stimulus and compares
// every output each cycle against a reference model that records accepted
// rows by advance index and looks up, per lane, the row accepted exactly
// "lane delay" advances ago.
// -----------------------------------------------------------------------------
module tb_skew_lane_buffer;
   localparam int BITS = 8;
   localparam int DIM  = 8;
   localparam int NADV = 4096;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   skew_lane_buffer_if #(.BITS(BITS), .DIM(DIM), .ROWS(8)) bus8 ();
   skew_lane_buffer_if #(.BITS(BITS), .DIM(DIM), .ROWS(4)) bus4 ();

   skew_lane_buffer #(.BITS(BITS), .DIM(DIM), .ROWS(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .bus(bus8));
   skew_lane_buffer #(.BITS(BITS), .DIM(DIM), .ROWS(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .bus(bus4));

   // reference model state
   int          t = 0;        // number of advancing (en=1) edges so far
   int          base = 0;     // advance index of the last reset
   bit          mode_m = 1'b0;
   int          cnt8 = 0, cnt4 = 0;
   bit          acc_v  [NADV];
   logic [63:0] acc_d  [NADV];
   bit          acc_l8 [NADV];
   bit          acc_l4 [NADV];

   int errors = 0, checks = 0, cyc = 0;

   // snapshots of the latest sample
   logic [63:0] s_dout8;
   logic [7:0]  s_vout8;
   logic        s_busy8, s_mode8, s_done8, s_done4;
   logic [3:0]  s_cnt8;
   logic [2:0]  s_cnt4;
   int          d8_n = 0, d8_at = -1, ff_n = 0;
   int          d4_q[$];

   function automatic int lat(int c);
      if (mode_m) return DIM - c;
      return c + 1;
   endfunction

   function automatic bit live(int a);
      if (a < base || a < 0 || a >= NADV) return 1'b0;
      return acc_v[a];
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input bit r_n, input bit e, input bit v,
                       input logic [63:0] d, input bit dsk);
      logic [63:0] e_dout;
      logic [7:0]  e_vout;
      bit          e_busy, e_d8, e_d4;
      int          a;
      @(negedge clk);
      rst_n = r_n;
      bus8.en = e; bus8.vin = v; bus8.din = d; bus8.deskew = dsk;
      bus4.en = e; bus4.vin = v; bus4.din = d; bus4.deskew = dsk;
      #1;
      e_dout = '0;
      e_vout = '0;
      for (int c = 0; c < DIM; c++) begin
         a = t - lat(c);
         if (live(a)) begin
            e_vout[c] = 1'b1;
            e_dout[c*8 +: 8] = acc_d[a][c*8 +: 8];
         end
      end
      e_busy = 1'b0;
      for (int k = t - DIM; k < t; k++) if (live(k)) e_busy = 1'b1;
      e_d8 = 1'b0;
      e_d4 = 1'b0;
      if (e && live(t - DIM)) begin
         e_d8 = acc_l8[t - DIM];
         e_d4 = acc_l4[t - DIM];
      end
      chk("dout8", 64'(bus8.dout), e_dout);
      chk("vout8", 64'(bus8.vout), 64'(e_vout));
      chk("busy8", 64'(bus8.busy), 64'(e_busy));
      chk("mode8", 64'(bus8.mode), 64'(mode_m));
      chk("done8", 64'(bus8.done), 64'(e_d8));
      chk("cnt8",  64'(bus8.row_cnt), 64'(cnt8));
      chk("dout4", 64'(bus4.dout), e_dout);
      chk("vout4", 64'(bus4.vout), 64'(e_vout));
      chk("busy4", 64'(bus4.busy), 64'(e_busy));
      chk("mode4", 64'(bus4.mode), 64'(mode_m));
      chk("done4", 64'(bus4.done), 64'(e_d4));
      chk("cnt4",  64'(bus4.row_cnt), 64'(cnt4));
      s_dout8 = bus8.dout;  s_vout8 = bus8.vout;  s_busy8 = bus8.busy;
      s_mode8 = bus8.mode;  s_done8 = bus8.done;  s_done4 = bus4.done;
      s_cnt8  = bus8.row_cnt; s_cnt4 = bus4.row_cnt;
      if (s_done8) begin d8_n++; d8_at = cyc; end
      if (s_done4) d4_q.push_back(cyc);
      if (s_vout8 == 8'hFF) ff_n++;
      @(posedge clk);
      if (!r_n) begin
         base = t; mode_m = 1'b0; cnt8 = 0; cnt4 = 0;
      end else begin
         if (!e_busy) mode_m = dsk;
         if (e) begin
            acc_v[t]  = v;
            acc_d[t]  = d;
            acc_l8[t] = v && (cnt8 == 7);
            acc_l4[t] = v && (cnt4 == 3);
            if (v) begin cnt8 = (cnt8 + 1) % 8; cnt4 = (cnt4 + 1) % 4; end
            t++;
         end
      end
      cyc++;
   endtask

   task automatic idle(input int n, input bit dsk);
      for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 64'd0, dsk);
   endtask

   task automatic feed_skew(input int rows, input bit dsk);
      logic [63:0] d;
      for (int r = 0; r < rows; r++) begin
         for (int c = 0; c < DIM; c++) d[c*8 +: 8] = 8'(r*8 + c);
         step(1'b1, 1'b1, 1'b1, d, dsk);
      end
   endtask

   int  s0;
   bit  found;
   bit  dsk_r;
   logic [63:0] rd;

   initial begin
      rst_n = 1'b0;
      bus8.en = 1'b0; bus8.vin = 1'b0; bus8.din = '0; bus8.deskew = 1'b0;
      bus4.en = 1'b0; bus4.vin = 1'b0; bus4.din = '0; bus4.deskew = 1'b0;

      // reset
      step(1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      step(1'b1, 1'b0, 1'b0, 64'd0, 1'b0);
      chk("rst_vout", 64'(s_vout8), 64'd0);
      chk("rst_cnt",  64'(s_cnt8), 64'd0);

      // skew frame of 8 rows, also two back-to-back frames on ROWS=4
      d8_n = 0; d4_q.delete();
      s0 = cyc;
      feed_skew(8, 1'b0);
      idle(16, 1'b0);
      chk("skew_done_n",   64'(d8_n), 64'd1);
      chk("skew_done_at",  64'(d8_at - s0), 64'd15);
      chk("skew_busy_end", 64'(s_busy8), 64'd0);
      chk("b2b_done_n",    64'(d4_q.size()), 64'd2);
      if (d4_q.size() == 2) chk("b2b_gap", 64'(d4_q[1] - d4_q[0]), 64'd4);

      // deskew: lane r carries 10+r on the r-th row
      idle(2, 1'b1);
      chk("dsk_mode", 64'(s_mode8), 64'd1);
      ff_n = 0; d8_n = 0;
      s0 = cyc;
      for (int r = 0; r < DIM; r++) begin
         rd = '0;
         rd[r*8 +: 8] = 8'(10 + r);
         step(1'b1, 1'b1, 1'b1, rd, 1'b1);
      end
      idle(1, 1'b1);
      chk("dsk_vout", 64'(s_vout8), 64'hFF);
      chk("dsk_dout", s_dout8, 64'h1110_0F0E_0D0C_0B0A);
      idle(16, 1'b1);
      chk("dsk_ff_n",    64'(ff_n), 64'd1);
      chk("dsk_done_at", 64'(d8_at - s0), 64'd15);
      idle(2, 1'b0);
      chk("dsk_back", 64'(s_mode8), 64'd0);

      // stall for 3 cycles mid-drain; vin/din during stall must be ignored
      d8_n = 0;
      s0 = cyc;
      feed_skew(8, 1'b0);
      idle(3, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, {$urandom, $urandom}, 1'b0);
      idle(16, 1'b0);
      chk("stall_done_n",  64'(d8_n), 64'd1);
      chk("stall_done_at", 64'(d8_at - s0), 64'd18);

      // mode request while busy is held off until the buffer empties
      feed_skew(1, 1'b0);
      feed_skew(2, 1'b1);
      chk("mc_hold", 64'(s_mode8), 64'd0);
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         idle(1, 1'b1);
         if (s_busy8 == 1'b0) found = 1'b1;
      end
      chk("mc_found", 64'(found), 64'd1);
      chk("mc_pre",   64'(s_mode8), 64'd0);
      idle(1, 1'b1);
      chk("mc_post",  64'(s_mode8), 64'd1);

      // reset with 3 deskew rows in flight
      feed_skew(3, 1'b1);
      d8_n = 0; d4_q.delete();
      step(1'b0, 1'b1, 1'b0, 64'd0, 1'b1);
      idle(1, 1'b1);
      chk("mr_dout", s_dout8, 64'd0);
      chk("mr_vout", 64'(s_vout8), 64'd0);
      chk("mr_busy", 64'(s_busy8), 64'd0);
      chk("mr_cnt8", 64'(s_cnt8), 64'd0);
      chk("mr_cnt4", 64'(s_cnt4), 64'd0);
      chk("mr_mode", 64'(s_mode8), 64'd0);
      idle(10, 1'b0);
      chk("mr_no_done", 64'(d8_n + d4_q.size()), 64'd0);

      // randomized traffic: stalls, bubbles, mode requests, occasional reset
      dsk_r = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(15, 0) == 0) dsk_r = ~dsk_r;
         step(($urandom_range(149, 0) != 0), ($urandom_range(5, 0) != 0),
              ($urandom_range(3, 0) != 0), {$urandom, $urandom}, dsk_r);
      end
      idle(20, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
